loc_sram_ctrl: RTL and testbench
================================

Name: loc_sram_ctrl

Overview:
- Sequencer/arbiter in front of the 16-row x 256-lane x 5-bit local SRAM (`loc_sram_16x1280b`, write-active-low `wsb`, mask bit 1 = keep old lane).
- Shares the single write port among NREQ element-write requesters using round-robin arbitration, with one lane written per grant.
- Serves a read port with optional clear-on-read, which replaces the "reset valid after read" behaviour.
- Zero-initialises all rows after reset.

Parameters:
- NREQ, 4, number of element-write requesters
- ROWS, 16, SRAM rows used
- RAW, 4, row index width (log2 ROWS)
- ADDR_SPACE, 8, SRAM address port width; upper bits driven 0
- D, 256, lanes per row
- LW, 8, lane index width (log2 D)
- BW, 5, bits per lane

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  NREQ  per-requester write request
- wr_ready  out  NREQ  grant; a transfer occurs when valid & ready
- wr_row  in  NREQ*RAW  target row; requester i at [i*RAW +: RAW]
- wr_lane  in  NREQ*LW  target lane (vid)
- wr_data  in  NREQ*BW  lane value
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted
- rd_row  in  RAW  row to read
- rd_clr  in  1  zero the row in the same cycle as the read
- rsp_valid  out  1  one-cycle pulse; rsp_data valid
- rsp_data  out  D*BW  row contents; no backpressure
- init_done  out  1  high once the zero sweep completes
- sram_wsb  out  1  write enable, active low
- sram_bytemask  out  D  1 = keep lane, 0 = write lane
- sram_wdata  out  D*BW  write data
- sram_waddr  out  ADDR_SPACE  write row
- sram_raddr  out  ADDR_SPACE  read row
- sram_rdata  in  D*BW  SRAM read data (1-cycle registered output)

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: state = INIT, init counter = 0, round-robin pointer = 0, init_done = 0, rsp_valid = 0, rsp_data = 0, read pipe valid bits = 0.
- SRAM drive when no write is issued: sram_wsb = 1, sram_bytemask all 1.
- Lane mapping: lane v occupies sram_wdata[(D-1-v)*BW +: BW] and bytemask bit D-1-v, so vid 0 is at the MSBs. Non-target lanes: wdata 0, mask 1.
- FSM INIT:
  - Each cycle writes row = counter with sram_wsb = 0, mask all 0, wdata 0.
  - Counter increments; after row ROWS-1 → RUN, init_done = 1 from the next cycle.
  - All wr_ready = 0 and rd_ready = 0 throughout INIT.
- FSM RUN, each cycle:
  - rd_ready = 1 always. A read is accepted when rd_valid = 1 and drives sram_raddr = rd_row combinationally.
  - If the accepted read has rd_clr = 1: write port issues a full-row zero write to rd_row (mask all 0). All wr_ready = 0 this cycle. The read returns pre-clear data.
  - Otherwise: round-robin among asserted wr_valid, starting at the pointer. The winner gets wr_ready = 1 and a single-lane write is issued. The pointer moves to winner+1 mod NREQ. Pointer is unchanged if there is no request.
  - A read without clear plus a write to the same row in the same cycle: read returns pre-write data (documented, not stalled).
  - A write in cycle t is visible to any read accepted in cycle ≥ t+1.
- Read latency: read accepted in cycle t → rsp_valid = 1 in cycle t+2, with rsp_data registered from sram_rdata. One read per cycle is fully pipelined.
- wr_ready is combinational from wr_valid and the pointer. Requesters must hold valid and payload stable until granted.
- rst_n low mid-operation: the next edge returns the block to INIT and re-zeroes all rows. In-flight reads are dropped; rsp_valid is never asserted for them.
- Out-of-range rows (≥ ROWS) are not checked; the simulation assertion is disabled.

Optional Feature:
- Macro LOC_SRAM_COALESCE_EN.
- Defined: after selecting the round-robin winner, every other valid requester with the same wr_row and a different wr_lane is also granted in the same cycle, with lanes merged into one masked write. On a duplicate lane, the winner (then the lowest index after the pointer) keeps the lane and the others stay ungranted. The pointer advances past the original winner only.
- Undefined: strictly one grant per cycle.

Decomposition:
- Package loc_sram_pkg: ROWS, D, BW, LW, RAW constants; FSM state enum {INIT, RUN}; lane-to-bit-offset function.
- Sub-module rr_arbiter_n: NREQ-wide round-robin with rotating pointer, reusable elsewhere.

Test Plan:
- Reset then idle → init_done rises 16 cycles after rst_n deasserts; reads of rows 0..15 all return 0; rsp_valid appears 2 cycles after each rd accept.
- Req0 writes row 3, lane 0, data 5'h1F; then read row 3 → rsp_data[1279:1275] = 5'h1F, all other bits 0.
- All 4 requesters valid continuously, distinct rows → grants ordered 0,1,2,3,0…; each wr_ready is a single-cycle pulse.
- Read row 5 with rd_clr = 1 while req2 is valid for row 5 → wr_ready all 0 that cycle; rsp carries the old row. In the next cycle req2 is granted; a subsequent read shows only req2's lane nonzero.
- Same-cycle read (no clear) and write on row 7, lane 255 = 5'h0A → that rsp shows the old lane; the next read shows rsp_data[4:0] = 5'h0A.
- LOC_SRAM_COALESCE_EN: req0..3 all on row 2, lanes 1,1,9,200 → req0, req2, req3 granted in one cycle (single wsb pulse); req1 granted the next cycle.

Source files
------------

// File: rtl/loc_sram_pkg.sv
// ---------------------------------------------------------------------------
// loc_sram_pkg : geometry constants, FSM encoding and lane mapping helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loc_sram_pkg;

  localparam int ROWS       = 16;
  localparam int RAW        = 4;
  localparam int ADDR_SPACE = 8;
  localparam int D          = 256;
  localparam int LW         = 8;
  localparam int BW         = 5;
  localparam int RW         = D * BW;
  localparam int OFFW       = $clog2(RW);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane 0 sits at the MSB end of the row.
  function automatic logic [OFFW-1:0] lane_off(input logic [LW-1:0] lane);
    return OFFW'((D - 1 - int'(lane)) * BW);
  endfunction

  function automatic logic [LW-1:0] lane_bit(input logic [LW-1:0] lane);
    return LW'(D - 1 - int'(lane));
  endfunction

endpackage

`default_nettype wire

// File: rtl/loc_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// loc_sram_ctrl_if : requester write port, read port and read response bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface loc_sram_ctrl_if #(
  parameter int NREQ = 4
);
  import loc_sram_pkg::*;

  logic [NREQ-1:0]     wr_valid;
  logic [NREQ-1:0]     wr_ready;
  logic [NREQ*RAW-1:0] wr_row;
  logic [NREQ*LW-1:0]  wr_lane;
  logic [NREQ*BW-1:0]  wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [RAW-1:0]      rd_row;
  logic                rd_clr;
  logic                rsp_valid;
  logic [D*BW-1:0]     rsp_data;

  modport master (
    output wr_valid, wr_row, wr_lane, wr_data, rd_valid, rd_row, rd_clr,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_row, wr_lane, wr_data, rd_valid, rd_row, rd_clr,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );

endinterface

`default_nettype wire

// File: rtl/loc_sram_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n : N-way round-robin arbiter, pointer moves to winner+1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_n #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [N-1:0]  req,
  output logic      [N-1:0]  grant,
  output logic      [PW-1:0] win,
  output logic               hit,
  output logic      [PW-1:0] ptr
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    win   = '0;
    hit   = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/loc_sram_ctrl.sv
// ---------------------------------------------------------------------------
// loc_sram_ctrl : zero-init sweep, round-robin lane writes, clear-on-read port
// Rev 1.0 | LOC_SRAM_COALESCE_EN merges same-row requests into one write
// ---------------------------------------------------------------------------
`default_nettype none

module loc_sram_ctrl
  import loc_sram_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  loc_sram_ctrl_if.slave             bus,
  output logic                       init_done,
  output logic                       sram_wsb,
  output logic      [D-1:0]          sram_bytemask,
  output logic      [D*BW-1:0]       sram_wdata,
  output logic      [ADDR_SPACE-1:0] sram_waddr,
  output logic      [ADDR_SPACE-1:0] sram_raddr,
  input  wire logic [D*BW-1:0]       sram_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [RAW-1:0]  init_cnt;
  logic            rd_pipe_v;
  logic            rd_acc;
  logic            clr_acc;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_win;
  logic [PW-1:0]   arb_ptr;
  logic            arb_hit;
  logic [PW-1:0]   scan;
  logic            take;

  logic [RAW-1:0]  req_row  [NREQ];
  logic [LW-1:0]   req_lane [NREQ];
  logic [BW-1:0]   req_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_row[i]  = bus.wr_row[i*RAW +: RAW];
    assign req_lane[i] = bus.wr_lane[i*LW +: LW];
    assign req_data[i] = bus.wr_data[i*BW +: BW];
  end

  assign rd_acc  = (state == RUN) && bus.rd_valid;
  assign clr_acc = rd_acc && bus.rd_clr;
  // A clearing read owns the write port, so requesters are hidden from the arbiter.
  assign arb_req = ((state == RUN) && !clr_acc) ? bus.wr_valid : '0;

  rr_arbiter_n #(
    .N (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .grant (arb_grant),
    .win   (arb_win),
    .hit   (arb_hit),
    .ptr   (arb_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (state_nxt == RUN) begin
        init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    sram_wsb      = 1'b1;
    sram_bytemask = '1;
    sram_wdata    = '0;
    sram_waddr    = '0;
    sram_raddr    = '0;
    bus.wr_ready  = '0;
    bus.rd_ready  = 1'b0;
    scan          = arb_ptr;
    take          = 1'b0;

    case (state)
      INIT: begin
        sram_wsb      = 1'b0;
        sram_bytemask = '0;
        sram_waddr    = ADDR_SPACE'(init_cnt);
        if (init_cnt == RAW'(ROWS - 1)) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        bus.rd_ready = 1'b1;
        if (rd_acc) begin
          sram_raddr = ADDR_SPACE'(bus.rd_row);
        end
        if (clr_acc) begin
          sram_wsb      = 1'b0;
          sram_bytemask = '0;
          sram_waddr    = ADDR_SPACE'(bus.rd_row);
        end else if (arb_hit) begin
          sram_wsb   = 1'b0;
          sram_waddr = ADDR_SPACE'(req_row[arb_win]);
          // Walk requesters in priority order; an already-claimed lane shows as mask 0.
          for (int i = 0; i < NREQ; i++) begin
            take = arb_grant[scan];
`ifdef LOC_SRAM_COALESCE_EN
            take = take || (bus.wr_valid[scan]
                            && (req_row[scan] == req_row[arb_win])
                            && sram_bytemask[lane_bit(req_lane[scan])]);
`endif
            if (take) begin
              bus.wr_ready[scan]                            = 1'b1;
              sram_bytemask[lane_bit(req_lane[scan])]       = 1'b0;
              sram_wdata[lane_off(req_lane[scan]) +: BW]    = req_data[scan];
            end
            scan = (scan == PW'(NREQ - 1)) ? '0 : scan + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // SRAM output is registered once more so the response lands two cycles after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe_v     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      rd_pipe_v     <= rd_acc;
      bus.rsp_valid <= rd_pipe_v;
      if (rd_pipe_v) begin
        bus.rsp_data <= sram_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_loc_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_loc_sram_ctrl : directed checks of loc_sram_ctrl against a simple SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_loc_sram_ctrl;
  import loc_sram_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  init_done;
  logic                  sram_wsb;
  logic [D-1:0]          sram_bytemask;
  logic [RW-1:0]         sram_wdata;
  logic [ADDR_SPACE-1:0] sram_waddr;
  logic [ADDR_SPACE-1:0] sram_raddr;
  logic [RW-1:0]         sram_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  loc_sram_ctrl_if #(.NREQ(4)) bus ();

  loc_sram_ctrl #(.NREQ(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .init_done     (init_done),
    .sram_wsb      (sram_wsb),
    .sram_bytemask (sram_bytemask),
    .sram_wdata    (sram_wdata),
    .sram_waddr    (sram_waddr),
    .sram_raddr    (sram_raddr),
    .sram_rdata    (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: read-before-write, registered read data, starts full of ones.
  logic [RW-1:0] mem [ROWS];
  logic          primed = 1'b0;

  always @(posedge clk) begin
    if (!primed) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '1;
      primed <= 1'b1;
    end
    if (!sram_wsb) begin
      for (int v = 0; v < D; v++) begin
        if (!sram_bytemask[v]) mem[sram_waddr[RAW-1:0]][v*BW +: BW] <= sram_wdata[v*BW +: BW];
      end
    end
    sram_rdata <= mem[sram_raddr[RAW-1:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] row, input logic [7:0] lane,
                         input logic [4:0] data);
    bus.wr_row[i*RAW +: RAW] = row;
    bus.wr_lane[i*LW +: LW]  = lane;
    bus.wr_data[i*BW +: BW]  = data;
  endtask

  function automatic logic [RW-1:0] lane_put(input logic [RW-1:0] r, input int lane,
                                             input logic [4:0] v);
    logic [RW-1:0] t;
    t = r;
    t[(255 - lane)*5 +: 5] = v;
    return t;
  endfunction

  task automatic read_row(input logic [3:0] row, output logic [RW-1:0] data, output int lat);
    bus.rd_valid = 1'b1;
    bus.rd_row   = row;
    bus.rd_clr   = 1'b0;
    step();
    bus.rd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      step();
      lat++;
    end
    data = bus.rsp_data;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    step();
    step();
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %0b want 0", init_done); else pass_cnt++;
    chk_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); else pass_cnt++;
    chk_cnt++; if (bus.rsp_data !== '0) $display("FAIL reset_rsp_data: got nonzero want 0"); else pass_cnt++;
    rst_n = 1'b1;
    bus.wr_valid = 4'hF;
    bus.rd_valid = 1'b1;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'h0) $display("FAIL init_wr_ready: got %h want 0", bus.wr_ready); else pass_cnt++;
    chk_cnt++; if (bus.rd_ready !== 1'b0) $display("FAIL init_rd_ready: got %0b want 0", bus.rd_ready); else pass_cnt++;
    chk_cnt++; if (sram_wsb !== 1'b0 || sram_bytemask !== '0 || sram_waddr !== 8'd0)
      $display("FAIL init_sweep_row0: wsb %0b waddr %0d want wsb 0 waddr 0 mask 0", sram_wsb, sram_waddr); else pass_cnt++;
    bus.wr_valid = 4'h0;
    bus.rd_valid = 1'b0;
    wait_init(n);
    chk_cnt++; if (n !== 16) $display("FAIL init_done_latency: got %0d cycles want 16", n); else pass_cnt++;
    chk_cnt++; if (bus.rd_ready !== 1'b1 || sram_wsb !== 1'b1)
      $display("FAIL run_idle: rd_ready %0b wsb %0b want 1 1", bus.rd_ready, sram_wsb); else pass_cnt++;
  endtask

  task automatic test_init_zero();
    logic [RW-1:0] d;
    int lat;
    for (int r = 0; r < ROWS; r++) begin
      read_row(4'(r), d, lat);
      chk_cnt++; if (lat !== 2) $display("FAIL zero_lat row %0d: got %0d want 2", r, lat); else pass_cnt++;
      chk_cnt++; if (d !== '0) $display("FAIL zero_data row %0d: got nonzero want 0", r); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [RW-1:0] d;
    int lat;
    for (int i = 0; i < 4; i++) set_req(i, 4'(8 + i), 8'(10 * (i + 1)), 5'(i + 1));
    bus.wr_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_cnt++; if (bus.wr_ready !== 4'(1 << (k % 4)))
        $display("FAIL rr_grant cycle %0d: got %h want %h", k, bus.wr_ready, 4'(1 << (k % 4))); else pass_cnt++;
      step();
    end
    bus.wr_valid = 4'h0;
    read_row(4'd9, d, lat);
    chk_cnt++; if (d !== lane_put('0, 20, 5'd2)) $display("FAIL rr_row9: got %h want lane20=2", d[1179:1175]); else pass_cnt++;
    step();
    step();
    bus.wr_valid = 4'b1010;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0010) $display("FAIL rr_sparse_a: got %h want 2", bus.wr_ready); else pass_cnt++;
    step();
    bus.wr_valid = 4'b1000;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b1000) $display("FAIL rr_sparse_b: got %h want 8", bus.wr_ready); else pass_cnt++;
    step();
    bus.wr_valid = 4'h0;
  endtask

  task automatic test_single_write();
    logic [RW-1:0] d;
    logic [D-1:0]  m;
    int lat;
    m = '1;
    m[255] = 1'b0;
    set_req(0, 4'd3, 8'd0, 5'h1F);
    bus.wr_valid = 4'b0001;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0001) $display("FAIL single_grant: got %h want 1", bus.wr_ready); else pass_cnt++;
    chk_cnt++; if (sram_wsb !== 1'b0 || sram_waddr !== 8'd3)
      $display("FAIL single_port: wsb %0b waddr %0d want 0 3", sram_wsb, sram_waddr); else pass_cnt++;
    chk_cnt++; if (sram_bytemask !== m || sram_wdata[1279:1275] !== 5'h1F || sram_wdata[1274:0] !== '0)
      $display("FAIL single_mask_data: lane0 data %h want 1f", sram_wdata[1279:1275]); else pass_cnt++;
    step();
    bus.wr_valid = 4'h0;
    read_row(4'd3, d, lat);
    chk_cnt++; if (d !== lane_put('0, 0, 5'h1F)) $display("FAIL single_readback: top %h want 1f", d[1279:1275]); else pass_cnt++;
    step();
  endtask

  task automatic test_clear_read();
    logic [RW-1:0] d;
    int lat;
    set_req(1, 4'd5, 8'd100, 5'h07);
    bus.wr_valid = 4'b0010;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0010) $display("FAIL clr_prefill: got %h want 2", bus.wr_ready); else pass_cnt++;
    step();
    bus.wr_valid = 4'b0100;
    set_req(2, 4'd5, 8'd50, 5'h15);
    bus.rd_valid = 1'b1;
    bus.rd_row   = 4'd5;
    bus.rd_clr   = 1'b1;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'h0) $display("FAIL clr_blocks_wr: got %h want 0", bus.wr_ready); else pass_cnt++;
    chk_cnt++; if (sram_wsb !== 1'b0 || sram_bytemask !== '0 || sram_waddr !== 8'd5 || sram_wdata !== '0)
      $display("FAIL clr_port: wsb %0b waddr %0d want 0 5 full zero", sram_wsb, sram_waddr); else pass_cnt++;
    step();
    bus.rd_valid = 1'b0;
    bus.rd_clr   = 1'b0;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0100) $display("FAIL clr_next_grant: got %h want 4", bus.wr_ready); else pass_cnt++;
    step();
    bus.wr_valid = 4'h0;
    chk_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== lane_put('0, 100, 5'h07))
      $display("FAIL clr_old_data: valid %0b lane100 %h want 1 07", bus.rsp_valid, bus.rsp_data[779:775]); else pass_cnt++;
    step();
    read_row(4'd5, d, lat);
    chk_cnt++; if (d !== lane_put('0, 50, 5'h15)) $display("FAIL clr_after: lane50 %h want 15 only", d[1029:1025]); else pass_cnt++;
    step();
  endtask

  task automatic test_same_cycle();
    set_req(3, 4'd7, 8'd255, 5'h03);
    bus.wr_valid = 4'b1000;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b1000) $display("FAIL same_prefill: got %h want 8", bus.wr_ready); else pass_cnt++;
    step();
    set_req(0, 4'd7, 8'd255, 5'h0A);
    bus.wr_valid = 4'b0001;
    bus.rd_valid = 1'b1;
    bus.rd_row   = 4'd7;
    bus.rd_clr   = 1'b0;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0001) $display("FAIL same_grant: got %h want 1", bus.wr_ready); else pass_cnt++;
    step();
    bus.wr_valid = 4'h0;
    step();
    bus.rd_valid = 1'b0;
    chk_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== lane_put('0, 255, 5'h03))
      $display("FAIL same_old: valid %0b lane255 %h want 1 03", bus.rsp_valid, bus.rsp_data[4:0]); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== lane_put('0, 255, 5'h0A))
      $display("FAIL same_new: valid %0b lane255 %h want 1 0a", bus.rsp_valid, bus.rsp_data[4:0]); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rsp_pulse: got %0b want 0", bus.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [RW-1:0] d;
    int lat;
    int n;
    bus.rd_valid = 1'b1;
    bus.rd_row   = 4'd7;
    step();
    bus.rd_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL midrst_drop_a: got %0b want 0", bus.rsp_valid); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rsp_valid !== 1'b0 || init_done !== 1'b0)
      $display("FAIL midrst_drop_b: rsp %0b init_done %0b want 0 0", bus.rsp_valid, init_done); else pass_cnt++;
    rst_n = 1'b1;
    wait_init(n);
    chk_cnt++; if (n !== 16) $display("FAIL midrst_init_latency: got %0d want 16", n); else pass_cnt++;
    read_row(4'd3, d, lat);
    chk_cnt++; if (d !== '0) $display("FAIL midrst_row3: got nonzero want 0"); else pass_cnt++;
    step();
    read_row(4'd7, d, lat);
    chk_cnt++; if (d !== '0) $display("FAIL midrst_row7: got nonzero want 0"); else pass_cnt++;
    step();
  endtask

  task automatic test_coalesce();
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    logic [D-1:0]  m;
    int lat;
    set_req(0, 4'd2, 8'd1,   5'h01);
    set_req(1, 4'd2, 8'd1,   5'h02);
    set_req(2, 4'd2, 8'd9,   5'h03);
    set_req(3, 4'd2, 8'd200, 5'h04);
    bus.wr_valid = 4'hF;
    m = '1;
    m[254] = 1'b0;
`ifdef LOC_SRAM_COALESCE_EN
    m[246] = 1'b0;
    m[55]  = 1'b0;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b1101) $display("FAIL coal_grant0: got %h want d", bus.wr_ready); else pass_cnt++;
    chk_cnt++; if (sram_wsb !== 1'b0 || sram_waddr !== 8'd2 || sram_bytemask !== m)
      $display("FAIL coal_write0: wsb %0b waddr %0d", sram_wsb, sram_waddr); else pass_cnt++;
    step();
    bus.wr_valid = 4'b0010;
    #1;
    chk_cnt++; if (bus.wr_ready !== 4'b0010) $display("FAIL coal_grant1: got %h want 2", bus.wr_ready); else pass_cnt++;
    step();
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++; if (bus.wr_ready !== 4'(1 << k)) $display("FAIL coal_grant%0d: got %h want %h", k, bus.wr_ready, 4'(1 << k)); else pass_cnt++;
      if (k == 0) begin
        chk_cnt++; if (sram_wsb !== 1'b0 || sram_waddr !== 8'd2 || sram_bytemask !== m)
          $display("FAIL coal_write0: wsb %0b waddr %0d", sram_wsb, sram_waddr); else pass_cnt++;
      end
      step();
      bus.wr_valid = bus.wr_valid & ~4'(1 << k);
    end
`endif
    bus.wr_valid = 4'h0;
    e = lane_put('0, 1, 5'h02);
    e = lane_put(e, 9, 5'h03);
    e = lane_put(e, 200, 5'h04);
    read_row(4'd2, d, lat);
    chk_cnt++; if (d !== e) $display("FAIL coal_row2: lane1 %h lane9 %h lane200 %h want 02 03 04",
                                     d[1274:1270], d[1234:1230], d[279:275]); else pass_cnt++;
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = '0;
    bus.wr_row   = '0;
    bus.wr_lane  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_row   = '0;
    bus.rd_clr   = 1'b0;
    test_reset();
    test_init_zero();
    test_round_robin();
    test_single_write();
    test_clear_read();
    test_same_cycle();
    test_mid_reset();
    test_coalesce();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
